// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port sram, with bounded burst locking.
// Define ARB_PERF_CNT_EN to add saturating grant/conflict counters and the perf_clr input.
module sram_port_arbiter #(
  parameter int unsigned ADDR_WID = 26,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned STRB_WID = DATA_WID / 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic                req0_lock,
  input  logic [ADDR_WID-1:0] req0_addr,
  input  logic [DATA_WID-1:0] req0_wdata,
  input  logic [STRB_WID-1:0] req0_wstrb,
  output logic                req0_ready,
  output logic                req0_rvalid,
  output logic [DATA_WID-1:0] req0_rdata,
  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic                req1_lock,
  input  logic [ADDR_WID-1:0] req1_addr,
  input  logic [DATA_WID-1:0] req1_wdata,
  input  logic [STRB_WID-1:0] req1_wstrb,
  output logic                req1_ready,
  output logic                req1_rvalid,
  output logic [DATA_WID-1:0] req1_rdata,
  output logic                ceb,
  output logic                wen,
  output logic [ADDR_WID-1:0] addr,
  output logic [DATA_WID-1:0] d,
  output logic [STRB_WID-1:0] be,
`ifdef ARB_PERF_CNT_EN
  input  logic [DATA_WID-1:0] q,
  input  logic                perf_clr,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1,
  output logic [15:0]         conflict_cnt
`else
  input  logic [DATA_WID-1:0] q
`endif
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rvalid0_q, rvalid1_q;
  logic                acc0, acc1, acc_any, lock_sel, other_valid;

  // Grant: round-robin when idle, owner-only while a burst lock is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          req0_ready = ~rr_q;
          req1_ready = rr_q;
        end else begin
          req0_ready = req0_valid;
          req1_ready = req1_valid;
        end
      end
      OWN0:    req0_ready = req0_valid;
      OWN1:    req1_ready = req1_valid;
      default: ;
    endcase
  end

  assign acc0        = req0_valid & req0_ready;
  assign acc1        = req1_valid & req1_ready;
  assign acc_any     = acc0 | acc1;
  assign lock_sel    = acc1 ? req1_lock : req0_lock;
  assign other_valid = acc1 ? req0_valid : req1_valid;

  // The sram access goes out in the same cycle as the accept.
  always_comb begin
    ceb  = acc_any;
    wen  = 1'b0;
    addr = '0;
    d    = '0;
    be   = '0;
    if (acc0) begin
      wen  = req0_write;
      addr = req0_addr;
      d    = req0_wdata;
      be   = req0_wstrb;
    end else if (acc1) begin
      wen  = req1_write;
      addr = req1_addr;
      d    = req1_wdata;
      be   = req1_wstrb;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (acc_any) begin
          rr_d = acc0;
          if (lock_sel) begin
            state_d = acc1 ? OWN1 : OWN0;
            hold_d  = HOLD_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        // An owner that drops valid releases the grant rather than blocking the other port.
        if (!acc_any || !lock_sel) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q >= HOLD_LAST) begin
          if (other_valid) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = HOLD_LAST;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      rvalid0_q <= acc0 & ~req0_write;
      rvalid1_q <= acc1 & ~req1_write;
    end
  end

  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = q;
  assign req1_rdata  = q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] gcnt0_q, gcnt1_q, ccnt_q;
  logic        conflict;

  assign conflict = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

  // Saturating event counters with synchronous clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else if (perf_clr) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (acc0 && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
      if (acc1 && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
      if (conflict && (ccnt_q != 16'hFFFF)) ccnt_q <= ccnt_q + 16'd1;
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a transaction-level arbitration/memory model predicts
// grants and sram bus values; predicted read responses are queued and matched by a monitor.
module tb_sram_port_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MH = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req0_valid, req0_write, req0_lock, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic [SW-1:0] req0_wstrb;
  logic          req1_valid, req1_write, req1_lock, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic [SW-1:0] req1_wstrb;
  logic          ceb, wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] d;
  logic [SW-1:0] be;
  logic [DW-1:0] q = '0;

  always #5 aclk = ~aclk;

  sram_port_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .STRB_WID(SW), .MAX_HOLD(MH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .ceb(ceb), .wen(wen), .addr(addr), .d(d), .be(be), .q(q)
  );

  typedef struct packed {
    logic          v;
    logic          w;
    logic          l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } req_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  localparam req_t NONE = '0;

  rsp_t          exp_q[$];
  rsp_t          mon_e;
  int            gl[$];
  int            n_checks = 0;
  int            n_fails = 0;
  int            own_m = -1;
  int            rr_m = 0;
  int            beats_m = 0;
  logic [DW-1:0] ref_mem [int unsigned];
  logic [DW-1:0] sram_mem [int unsigned];
  logic [DW-1:0] last_rd0 = '0;
  logic [DW-1:0] last_rd1 = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic req_t mk(input logic w, input logic l, input int unsigned a,
                             input logic [DW-1:0] dd, input logic [SW-1:0] s);
    req_t r;
    r.v = 1'b1; r.w = w; r.l = l; r.a = AW'(a); r.d = dd; r.s = s;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural single-port sram with one-cycle read latency.
  always @(posedge aclk) begin
    if (ceb) begin
      if (wen) sram_mem[32'(addr)] = merge(sram_mem.exists(32'(addr)) ? sram_mem[32'(addr)] : '0, d, be);
      else q = sram_mem.exists(32'(addr)) ? sram_mem[32'(addr)] : '0;
    end
  end

  // Monitor: every rvalid must match the oldest predicted read response.
  always @(posedge aclk) begin
    #1;
    if (aresetn) begin
      if (req0_rvalid || req1_rvalid) begin
        chk("rvalid_onehot", 64'(req0_rvalid & req1_rvalid), 64'd0);
        if (exp_q.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_port", 64'(req1_rvalid), 64'(mon_e.port));
          chk("rdata", 64'(req1_rvalid ? req1_rdata : req0_rdata), 64'(mon_e.data));
        end
        if (req0_rvalid) last_rd0 = req0_rdata;
        if (req1_rvalid) last_rd1 = req1_rdata;
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rvalid_missing", 64'd0, 64'd1);
      end
    end
  end

  task automatic drive(input req_t r0, input req_t r1);
    req0_valid = r0.v; req0_write = r0.w; req0_lock = r0.l;
    req0_addr = r0.a; req0_wdata = r0.d; req0_wstrb = r0.s;
    req1_valid = r1.v; req1_write = r1.w; req1_lock = r1.l;
    req1_addr = r1.a; req1_wdata = r1.d; req1_wstrb = r1.s;
  endtask

  task automatic model_reset();
    own_m = -1; rr_m = 0; beats_m = 0;
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, predict the winner, compare the bus, update the model.
  task automatic step(input req_t r0, input req_t r1);
    int   g;
    req_t w;
    logic vo;
    rsp_t e;
    drive(r0, r1);
    #1;
    if (own_m < 0) begin
      if (r0.v && r1.v) g = rr_m;
      else if (r0.v)    g = 0;
      else if (r1.v)    g = 1;
      else              g = -1;
    end else begin
      g = ((own_m == 0) ? r0.v : r1.v) ? own_m : -1;
    end
    chk("ready0", 64'(req0_ready), 64'(g == 0));
    chk("ready1", 64'(req1_ready), 64'(g == 1));
    chk("ceb", 64'(ceb), 64'(g >= 0));
    gl.push_back(req1_ready ? 1 : (req0_ready ? 0 : -1));
    if (g >= 0) begin
      w  = (g == 1) ? r1 : r0;
      vo = (g == 1) ? r0.v : r1.v;
      chk("wen", 64'(wen), 64'(w.w));
      chk("addr", 64'(addr), 64'(w.a));
      if (w.w) begin
        chk("d", 64'(d), 64'(w.d));
        chk("be", 64'(be), 64'(w.s));
        ref_mem[32'(w.a)] = merge(ref_mem.exists(32'(w.a)) ? ref_mem[32'(w.a)] : '0, w.d, w.s);
      end else begin
        e.port = (g == 1);
        e.data = ref_mem.exists(32'(w.a)) ? ref_mem[32'(w.a)] : '0;
        exp_q.push_back(e);
      end
      if (own_m < 0) begin
        rr_m = 1 - g;
        beats_m = 1;
        own_m = w.l ? g : -1;
      end else begin
        beats_m++;
        if (!w.l) own_m = -1;
        else if (beats_m >= MH && vo) own_m = -1;
      end
    end else begin
      chk("idle_bus", 64'({wen, addr, d, be}), 64'd0);
      own_m = -1;
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    drive(NONE, NONE);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("rst_rvalid0", 64'(req0_rvalid), 64'd0);
    chk("rst_rvalid1", 64'(req1_rvalid), 64'd0);
    chk("rst_ceb", 64'(ceb), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    int p0;
    int zeros;
    logic p1_done;
    req_t a, b;

    drive(NONE, NONE);
    @(negedge aclk);
    do_reset();

    // Single-port write then read-back.
    step(mk(1, 0, 'h10, 32'hDEADBEEF, 4'hF), NONE);
    step(mk(0, 0, 'h10, '0, '0), NONE);
    step(NONE, NONE);
    step(NONE, NONE);
    chk("wr_rd_rdata0", 64'(last_rd0), 64'h0000_0000_DEAD_BEEF);

    // Alternating grants from reset under constant contention.
    do_reset();
    gl.delete();
    for (int i = 0; i < 6; i++) step(mk(0, 0, i, '0, '0), mk(0, 0, 8 + i, '0, '0));
    for (int i = 0; i < 6; i++) chk("alt_grant", 64'(gl[i]), 64'(i % 2));

    // Locked burst of four, then the waiting port.
    gl.delete();
    for (int i = 0; i < 4; i++) step(mk(0, (i < 3), i, '0, '0), mk(0, 0, 'h30, '0, '0));
    step(mk(0, 0, 'h1, '0, '0), mk(0, 0, 'h31, '0, '0));
    for (int i = 0; i < 4; i++) chk("burst_p0", 64'(gl[i]), 64'd0);
    chk("burst_handover", 64'(gl[4]), 64'd1);

    // Lock held past MAX_HOLD forces one handover.
    gl.delete();
    p0 = 0;
    p1_done = 1'b0;
    for (int i = 0; i < 40 && p0 < 20; i++) begin
      step(mk(1, 1, 'h40 + i, $urandom, 4'hF), p1_done ? NONE : mk(0, 0, 'h30, '0, '0));
      if (gl[gl.size() - 1] == 0) p0++;
      else if (gl[gl.size() - 1] == 1) p1_done = 1'b1;
    end
    step(NONE, NONE);
    zeros = 0;
    for (int i = 0; i < MH; i++) if (gl[i] == 0) zeros++;
    chk("hold_p0_run", 64'(zeros), 64'(MH));
    chk("hold_handover", 64'(gl[MH]), 64'd1);
    chk("hold_resume", 64'(gl[MH + 1]), 64'd0);

    // Byte strobes merge across ports.
    step(mk(1, 0, 'h20, 32'hFFFFFFFF, 4'hF), NONE);
    step(NONE, mk(1, 0, 'h20, 32'h00000000, 4'b0101));
    step(mk(0, 0, 'h20, '0, '0), NONE);
    step(NONE, NONE);
    step(NONE, NONE);
    chk("strobe_merge", 64'(last_rd0), 64'h0000_0000_FF00_FF00);

    // Reset while port1 owns the sram with a read in flight.
    step(NONE, mk(0, 1, 'h20, '0, '0));
    drive(mk(0, 0, 'h10, '0, '0), mk(0, 1, 'h21, '0, '0));
    #1;
    chk("own1_ready1", 64'(req1_ready), 64'd1);
    chk("own1_stall0", 64'(req0_ready), 64'd0);
    #1;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("rst_drop_rvalid1", 64'(req1_rvalid), 64'd0);
    chk("rst_idle_rr0", 64'(req0_ready), 64'd1);
    @(posedge aclk);
    #1;
    chk("rst_hold_rvalid1", 64'(req1_rvalid), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    gl.delete();
    step(mk(0, 0, 'h10, '0, '0), mk(0, 0, 'h20, '0, '0));
    chk("rst_first_grant", 64'(gl[0]), 64'd0);

    // Randomized traffic with heavy contention and frequent locks.
    for (int i = 0; i < 500; i++) begin
      a = mk(1'($urandom), ($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom, 4'($urandom));
      b = mk(1'($urandom), ($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom, 4'($urandom));
      a.v = ($urandom_range(0, 3) != 0);
      b.v = ($urandom_range(0, 3) != 0);
      step(a, b);
    end
    step(NONE, NONE);
    step(NONE, NONE);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
